// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter (and a future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // Serial bits in one frame: start + data + optional parity + stop.
    function automatic int uart_frame_bits(input int data_bits, input int stop_bits,
                                           input int parity_en);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Core-to-transmitter valid/ready word handshake.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data_in;
    logic                 tx_valid_in;
    logic                 tx_ready_out;

    modport master (output tx_data_in, output tx_valid_in, input tx_ready_out);
    modport slave  (input tx_data_in, input tx_valid_in, output tx_ready_out);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    output logic bit_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_tick = (cnt == CNT_MAX);

    always_ff @(posedge clk_in) begin
        if (rst_in || clear)
            cnt <= '0;
        else if (bit_tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1-style serial transmitter with a one-word holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    uart_tx_if.slave      tx,
    output logic          txd_out,
    output logic          tx_busy_out
);
    localparam int BIT_W = $clog2(DATA_BITS);

    tx_state_t            state, state_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shifter, shift_n;
    logic [DATA_BITS-1:0] hold_data, hold_d_n;
    logic                 hold_valid, hold_v_n;
    logic                 txd_n;
    logic                 bit_tick;
    logic                 accept;
    logic                 last_stop;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit, par_n;
`endif

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear    (state == IDLE),
        .bit_tick (bit_tick)
    );

    assign tx.tx_ready_out = !hold_valid;
    assign accept          = tx.tx_valid_in && tx.tx_ready_out;
    assign last_stop       = (state == STOP) && bit_tick &&
                             (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign tx_busy_out     = (state != IDLE) || hold_valid;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shifter    <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            txd_out    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_n;
            shifter    <= shift_n;
            hold_data  <= hold_d_n;
            hold_valid <= hold_v_n;
            txd_out    <= txd_n;
`ifdef UART_TX_PARITY_EN
            par_bit    <= par_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        shift_n  = shifter;
        hold_d_n = hold_data;
        hold_v_n = hold_valid;
        txd_n    = txd_out;
`ifdef UART_TX_PARITY_EN
        par_n    = par_bit;
`endif

        // A word arriving on the final stop edge bypasses hold and starts at once.
        if (accept && state != IDLE && !last_stop) begin
            hold_d_n = tx.tx_data_in;
            hold_v_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    shift_n = tx.tx_data_in;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^tx.tx_data_in;
`endif
                    state_n = START;
                    txd_n   = UART_START_LEVEL;
                end
            end
            START: begin
                if (bit_tick) begin
                    txd_n   = shifter[0];
                    shift_n = {1'b0, shifter[DATA_BITS-1:1]};
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = par_bit;
`else
                        state_n = STOP;
                        txd_n   = UART_IDLE_LEVEL;
`endif
                    end else begin
                        bit_n   = bit_cnt + BIT_W'(1);
                        txd_n   = shifter[0];
                        shift_n = {1'b0, shifter[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_n = STOP;
                    txd_n   = UART_IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (last_stop) begin
                    if (hold_valid) begin
                        shift_n  = hold_data;
`ifdef UART_TX_PARITY_EN
                        par_n    = ^hold_data;
`endif
                        hold_v_n = 1'b0;
                        state_n  = START;
                        txd_n    = UART_START_LEVEL;
                    end else if (accept) begin
                        shift_n  = tx.tx_data_in;
`ifdef UART_TX_PARITY_EN
                        par_n    = ^tx.tx_data_in;
`endif
                        state_n  = START;
                        txd_n    = UART_START_LEVEL;
                    end else begin
                        state_n  = IDLE;
                    end
                end else if (bit_tick) begin
                    bit_n = bit_cnt + BIT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = UART_IDLE_LEVEL;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at 1 clk/bit, one at 4 clks/bit.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic clk, rst;
    logic txd1, busy1, txd4, busy4;
    int   n_chk, n_fail;
    vec_t vecs[9];
    vec_t seq[3];

    uart_tx_if #(.DATA_BITS(8)) bus1();
    uart_tx_if #(.DATA_BITS(8)) bus4();

    uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8), .STOP_BITS(1)) u1 (
        .clk_in(clk), .rst_in(rst), .tx(bus1), .txd_out(txd1), .tx_busy_out(busy1));
    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) u4 (
        .clk_in(clk), .rst_in(rst), .tx(bus4), .txd_out(txd4), .tx_busy_out(busy4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line level for bit idx of a frame carrying d with parity p.
    function automatic logic fbit(input logic [7:0] d, input logic p, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return p;
`endif
        return 1'b1;
    endfunction

    function automatic logic seq_bit(input int n, input int i);
        if (i >= n * FB) return 1'b1;
        return fbit(seq[i / FB].data, seq[i / FB].par, i % FB);
    endfunction

    initial begin
        int busy_cnt;
        n_chk = 0;
        n_fail = 0;
        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b0};
        vecs[2] = '{8'h07, 1'b1};
        vecs[3] = '{8'h03, 1'b0};
        vecs[4] = '{8'h00, 1'b0};
        vecs[5] = '{8'hFF, 1'b0};
        vecs[6] = '{8'h80, 1'b1};
        vecs[7] = '{8'h12, 1'b0};
        vecs[8] = '{8'h34, 1'b1};

        rst = 1'b1;
        bus1.tx_valid_in = 1'b0; bus1.tx_data_in = 8'h00;
        bus4.tx_valid_in = 1'b0; bus4.tx_data_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_txd1", txd1, 1'b1);
        chk("rst_ready1", bus1.tx_ready_out, 1'b1);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_txd4", txd4, 1'b1);
        chk("rst_ready4", bus4.tx_ready_out, 1'b1);
        chk("rst_busy4", busy4, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // Single frames from idle, one bit per clock.
        for (int v = 0; v < 9; v++) begin
            @(posedge clk); #1;
            bus1.tx_valid_in = 1'b1; bus1.tx_data_in = vecs[v].data;
            @(posedge clk); #1;
            bus1.tx_valid_in = 1'b0; bus1.tx_data_in = 8'hXX;
            for (int i = 0; i < FB; i++) begin
                @(negedge clk);
                chk($sformatf("tbl%0d_txd[%0d]", v, i), txd1, fbit(vecs[v].data, vecs[v].par, i));
                chk($sformatf("tbl%0d_ready[%0d]", v, i), bus1.tx_ready_out, 1'b1);
                chk($sformatf("tbl%0d_busy[%0d]", v, i), busy1, 1'b1);
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_idle_txd", v), txd1, 1'b1);
            chk($sformatf("tbl%0d_idle_busy", v), busy1, 1'b0);
        end

        // 0xA3 at four clocks per bit; busy must cover exactly the frame.
        @(posedge clk); #1;
        bus4.tx_valid_in = 1'b1; bus4.tx_data_in = 8'hA3;
        @(posedge clk); #1;
        bus4.tx_valid_in = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 4 * FB + 4; i++) begin
            @(negedge clk);
            chk($sformatf("cpb4_txd[%0d]", i), txd4, fbit(8'hA3, 1'b0, i / 4));
            if (busy4) busy_cnt++;
        end
        chk("cpb4_busy_cycles", busy_cnt, 4 * FB);

        // Back-to-back with valid held high: 0x12, 0x34 (held), 0x56 (after hold frees).
        seq[0] = '{8'h12, 1'b0}; seq[1] = '{8'h34, 1'b1}; seq[2] = '{8'h56, 1'b0};
        bus1.tx_valid_in = 1'b1; bus1.tx_data_in = 8'h12;
        for (int i = 0; i < 3 * FB + 1; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus1.tx_data_in = 8'h34;
            if (i == 1) bus1.tx_data_in = 8'h56;
            if (i == FB + 1) bus1.tx_valid_in = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b_txd[%0d]", i), txd1, seq_bit(3, i));
            if (i == 1 || i == FB - 1 || i == FB + 1)
                chk($sformatf("b2b_ready[%0d]", i), bus1.tx_ready_out, 1'b0);
            if (i == FB)
                chk("b2b_ready_freed", bus1.tx_ready_out, 1'b1);
        end
        chk("b2b_end_busy", busy1, 1'b0);

        // valid toggling while hold is full must not capture extra words.
        seq[0] = '{8'hA5, 1'b0}; seq[1] = '{8'h3C, 1'b0};
        @(posedge clk); #1;
        bus1.tx_valid_in = 1'b1; bus1.tx_data_in = 8'hA5;
        for (int i = 0; i < 2 * FB + 2; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus1.tx_data_in = 8'h3C;
            if (i >= 1 && i <= FB - 2) begin
                bus1.tx_valid_in = (i % 2 == 1);
                bus1.tx_data_in = 8'hEE;
            end
            if (i == FB - 1) bus1.tx_valid_in = 1'b0;
            @(negedge clk);
            chk($sformatf("tog_txd[%0d]", i), txd1, seq_bit(2, i));
        end
        chk("tog_end_busy", busy1, 1'b0);

        // Handshake lands exactly on the final stop edge with hold empty.
        seq[0] = '{8'h5A, 1'b0}; seq[1] = '{8'hC3, 1'b0};
        @(posedge clk); #1;
        bus1.tx_valid_in = 1'b1; bus1.tx_data_in = 8'h5A;
        for (int i = 0; i < 2 * FB + 2; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus1.tx_valid_in = 1'b0;
            if (i == FB - 1) begin
                bus1.tx_valid_in = 1'b1; bus1.tx_data_in = 8'hC3;
            end
            if (i == FB) bus1.tx_valid_in = 1'b0;
            @(negedge clk);
            chk($sformatf("edge_txd[%0d]", i), txd1, seq_bit(2, i));
        end
        chk("edge_end_busy", busy1, 1'b0);

        // Reset at cycle 5 of a 0xFF frame with 0x81 held.
        @(posedge clk); #1;
        bus1.tx_valid_in = 1'b1; bus1.tx_data_in = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus1.tx_data_in = 8'h81;
            if (i == 1) begin bus1.tx_valid_in = 1'b0; bus1.tx_data_in = 8'h00; end
            if (i == 2) bus1.tx_valid_in = 1'b1;
            if (i == 3) bus1.tx_valid_in = 1'b0;
            if (i == 4) rst = 1'b1;
            @(negedge clk);
            chk($sformatf("rstmid_txd[%0d]", i), txd1, fbit(8'hFF, 1'b0, i));
        end
        chk("rstmid_held_ready", bus1.tx_ready_out, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_txd", txd1, 1'b1);
        chk("rstmid_ready", bus1.tx_ready_out, 1'b1);
        chk("rstmid_busy", busy1, 1'b0);
        for (int i = 0; i < 2 * FB; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid_quiet_txd[%0d]", i), txd1, 1'b1);
            chk($sformatf("rstmid_quiet_busy[%0d]", i), busy1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
